ps2_scan_receiver: RTL and testbench

//  Deserialises PS/2 keyboard frames from PS2Clk/PS2Data into scan-code bytes.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_input_filter.sv | 38 +++
 rtl/ps2_scan_receiver.sv | 158 +++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: FSM encoding, prefix codes, frame size.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         FRAME_BITS = 11;

  // Data byte plus parity bit must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one PS/2 line.
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      filt    <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // Any sample agreeing with the current output restarts the run count.
      if (sync_p1 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        filt <= sync_p1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver: filtered line inputs, frame FSM, prefix tracking, error pulses.
// Define PS2_PARITY_CHECK_EN to reject frames with a bad odd-parity bit.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err
);

  localparam int         TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 2);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk_f;
  logic             dat_f;
  logic             clk_f_p1;
  logic             fall_p;
  state_e           state;
  state_e           nxt_state;
  logic [3:0]       bit_cnt;
  logic [TMO_W-1:0] tmo;
  logic [9:0]       sr;
  logic [7:0]       rx_byte;
  logic             brk_pend;
  logic             ext_pend;
  logic             tmo_hit;
  logic             par_fail;
  logic             err_c;
  logic             valid_c;
  logic             set_brk;
  logic             set_ext;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (PS2Clk),
    .filt (clk_f)
  );

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (PS2Data),
    .filt (dat_f)
  );

  // Edge-detect stage: one-cycle pulse on filtered clock falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_f_p1 <= 1'b1;
      fall_p   <= 1'b0;
    end else begin
      clk_f_p1 <= clk_f;
      fall_p   <= clk_f_p1 & ~clk_f;
    end
  end

  assign rx_byte  = sr[7:0];
  assign tmo_hit  = (state == SHIFT) && !fall_p && (tmo == TMO_W'(TIMEOUT_CYC));
  assign par_fail = PAR_EN && !odd_parity_ok(sr[8:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:  if (fall_p && !dat_f) nxt_state = SHIFT;
      SHIFT: begin
        if (fall_p && (bit_cnt == LAST_BIT)) nxt_state = CHECK;
        else if (tmo_hit)                    nxt_state = IDLE;
      end
      CHECK:   nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    err_c   = 1'b0;
    valid_c = 1'b0;
    set_brk = 1'b0;
    set_ext = 1'b0;
    case (state)
      SHIFT: err_c = tmo_hit;
      CHECK: begin
        if (!sr[9] || par_fail)         err_c   = 1'b1;
        else if (rx_byte == BREAK_CODE) set_brk = 1'b1;
        else if (rx_byte == EXT_CODE)   set_ext = 1'b1;
        else                            valid_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      tmo     <= '0;
    end else begin
      if (state != SHIFT)  bit_cnt <= '0;
      else if (fall_p)     bit_cnt <= bit_cnt + 1'b1;
      if ((state == SHIFT) && !fall_p) tmo <= tmo + 1'b1;
      else                             tmo <= '0;
    end
  end

  // Bits arrive LSB first, so shift right: after ten shifts sr = {stop, parity, d7..d0}
  always_ff @(posedge clk) begin
    if ((state == SHIFT) && fall_p) sr <= {dat_f, sr[9:1]};
  end

  // Output stage: registered pulses and held code/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      hex1        <= 4'h0;
      hex0        <= 4'h0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
      brk_pend    <= 1'b0;
      ext_pend    <= 1'b0;
    end else begin
      code_valid <= valid_c;
      frame_err  <= err_c;
      if (valid_c) begin
        {hex1, hex0} <= rx_byte;
        is_break     <= brk_pend;
        is_extended  <= ext_pend;
      end
      if (err_c || valid_c) begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end else begin
        if (set_brk) brk_pend <= 1'b1;
        if (set_ext) ext_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: directed scenarios plus randomized frames against a frame-level model.
module tb_ps2_scan_receiver;

  localparam int HP  = 30;
  localparam int TMO = 2000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       PS2Clk;
  logic       PS2Data;
  logic [3:0] hex1;
  logic [3:0] hex0;
  logic       code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cv_tot = 0;
  int fe_tot = 0;

  // Frame-level reference model state
  bit         m_brk, m_ext;
  logic [7:0] e_hex;
  bit         e_brk, e_ext;
  int         e_cv, e_fe;

  always #5 clk = ~clk;

  ps2_scan_receiver #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .PS2Clk      (PS2Clk),
    .PS2Data     (PS2Data),
    .hex1        (hex1),
    .hex0        (hex0),
    .code_valid  (code_valid),
    .is_break    (is_break),
    .is_extended (is_extended),
    .frame_err   (frame_err)
  );

  always @(negedge clk) begin
    if (code_valid) cv_tot <= cv_tot + 1;
    if (frame_err)  fe_tot <= fe_tot + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic model_reset();
    m_brk = 0; m_ext = 0; e_hex = 8'h00; e_brk = 0; e_ext = 0;
  endtask

  task automatic model_error();
    e_fe++; m_brk = 0; m_ext = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop);
    if (!stop || (PAR_EN && !par_ok)) begin
      model_error();
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      e_cv++; e_hex = b; e_brk = m_brk; e_ext = m_ext; m_brk = 0; m_ext = 0;
    end
  endtask

  // Drive the first nbits of a frame; glitch_at >= 0 injects a 3-cycle low pulse on PS2Clk in that bit
  task automatic send(input logic [7:0] b, input bit par_ok, input bit stop,
                      input int nbits, input int glitch_at, input int idle);
    logic [10:0] f;
    f = {stop, (par_ok ? ~^b : ^b), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2Data = f[i];
      if (i == glitch_at) begin
        wait_clk(8); PS2Clk = 1'b0; wait_clk(3); PS2Clk = 1'b1; wait_clk(HP - 11);
      end else begin
        wait_clk(HP);
      end
      PS2Clk = 1'b0;
      wait_clk(HP);
      PS2Clk = 1'b1;
    end
    PS2Data = 1'b1;
    wait_clk(idle);
  endtask

  task automatic frame(input logic [7:0] b, input bit par_ok, input bit stop);
    send(b, par_ok, stop, 11, -1, 4 * HP);
    model_frame(b, par_ok, stop);
  endtask

  task automatic test_reset();
    rst = 1'b1; PS2Clk = 1'b1; PS2Data = 1'b1;
    model_reset(); e_cv = 0; e_fe = 0;
    wait_clk(10);
    @(negedge clk);
    n_cmp++;
    if ({hex1, hex0, code_valid, is_break, is_extended, frame_err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 000",
               {hex1, hex0, code_valid, is_break, is_extended, frame_err});
    end
    rst = 1'b0;
    wait_clk(20);
  endtask

  task automatic test_basic();
    frame(8'h1B, 1'b1, 1'b1);
    n_cmp++;
    if (cv_tot !== e_cv || fe_tot !== e_fe) begin
      n_fail++; $display("FAIL basic_pulses: cv=%0d fe=%0d required cv=%0d fe=%0d", cv_tot, fe_tot, e_cv, e_fe);
    end
    n_cmp++;
    if ({hex1, hex0, is_break, is_extended} !== {8'h1B, 2'b00}) begin
      n_fail++; $display("FAIL basic_code: got %h/%b%b required 1B/00", {hex1, hex0}, is_break, is_extended);
    end
  endtask

  task automatic test_prefix();
    frame(8'hE0, 1'b1, 1'b1);
    frame(8'h75, 1'b1, 1'b1);
    n_cmp++;
    if (cv_tot !== e_cv || fe_tot !== e_fe) begin
      n_fail++; $display("FAIL ext_pulses: cv=%0d fe=%0d required cv=%0d fe=%0d", cv_tot, fe_tot, e_cv, e_fe);
    end
    n_cmp++;
    if ({hex1, hex0, is_break, is_extended} !== {8'h75, 2'b01}) begin
      n_fail++; $display("FAIL ext_code: got %h/%b%b required 75/01", {hex1, hex0}, is_break, is_extended);
    end
    frame(8'hE0, 1'b1, 1'b1);
    frame(8'hF0, 1'b1, 1'b1);
    frame(8'h75, 1'b1, 1'b1);
    n_cmp++;
    if (cv_tot !== e_cv || fe_tot !== e_fe) begin
      n_fail++; $display("FAIL extbrk_pulses: cv=%0d fe=%0d required cv=%0d fe=%0d", cv_tot, fe_tot, e_cv, e_fe);
    end
    n_cmp++;
    if ({hex1, hex0, is_break, is_extended} !== {8'h75, 2'b11}) begin
      n_fail++; $display("FAIL extbrk_code: got %h/%b%b required 75/11", {hex1, hex0}, is_break, is_extended);
    end
  endtask

  task automatic test_parity();
    frame(8'h76, 1'b0, 1'b1);
    n_cmp++;
    if (cv_tot !== e_cv || fe_tot !== e_fe) begin
      n_fail++; $display("FAIL parity_pulses: cv=%0d fe=%0d required cv=%0d fe=%0d", cv_tot, fe_tot, e_cv, e_fe);
    end
    n_cmp++;
    if ({hex1, hex0, is_break, is_extended} !== {e_hex, e_brk, e_ext}) begin
      n_fail++; $display("FAIL parity_code: got %h/%b%b required %h/%b%b",
                         {hex1, hex0}, is_break, is_extended, e_hex, e_brk, e_ext);
    end
  endtask

  task automatic test_stop_err();
    frame(8'hF0, 1'b1, 1'b1);
    frame(8'h4D, 1'b1, 1'b0);
    n_cmp++;
    if (cv_tot !== e_cv || fe_tot !== e_fe) begin
      n_fail++; $display("FAIL stop_pulses: cv=%0d fe=%0d required cv=%0d fe=%0d", cv_tot, fe_tot, e_cv, e_fe);
    end
    frame(8'h4D, 1'b1, 1'b1);
    n_cmp++;
    if ({hex1, hex0, is_break, is_extended} !== {8'h4D, 2'b00}) begin
      n_fail++; $display("FAIL stop_recover: got %h/%b%b required 4D/00", {hex1, hex0}, is_break, is_extended);
    end
  endtask

  task automatic test_timeout();
    frame(8'hE0, 1'b1, 1'b1);
    send(8'h2D, 1'b1, 1'b1, 5, -1, TMO + 500);
    model_error();
    n_cmp++;
    if (cv_tot !== e_cv || fe_tot !== e_fe) begin
      n_fail++; $display("FAIL timeout_pulses: cv=%0d fe=%0d required cv=%0d fe=%0d", cv_tot, fe_tot, e_cv, e_fe);
    end
    frame(8'h2D, 1'b1, 1'b1);
    n_cmp++;
    if (cv_tot !== e_cv || {hex1, hex0, is_break, is_extended} !== {8'h2D, 2'b00}) begin
      n_fail++; $display("FAIL timeout_recover: cv=%0d got %h/%b%b required cv=%0d 2D/00",
                         cv_tot, {hex1, hex0}, is_break, is_extended, e_cv);
    end
  endtask

  task automatic test_glitch();
    send(8'h3C, 1'b1, 1'b1, 11, 4, 4 * HP);
    model_frame(8'h3C, 1'b1, 1'b1);
    n_cmp++;
    if (cv_tot !== e_cv || fe_tot !== e_fe || {hex1, hex0} !== 8'h3C) begin
      n_fail++; $display("FAIL glitch: cv=%0d fe=%0d hex=%h required cv=%0d fe=%0d hex=3C",
                         cv_tot, fe_tot, {hex1, hex0}, e_cv, e_fe);
    end
  endtask

  task automatic test_rst_mid();
    frame(8'hE0, 1'b1, 1'b1);
    send(8'h5A, 1'b1, 1'b1, 4, -1, 10);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    model_reset();
    wait_clk(4 * HP);
    n_cmp++;
    if ({hex1, hex0, code_valid, is_break, is_extended, frame_err} !== 12'h000 || fe_tot !== e_fe) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h fe=%0d required 000 fe=%0d",
                         {hex1, hex0, code_valid, is_break, is_extended, frame_err}, fe_tot, e_fe);
    end
    frame(8'h5A, 1'b1, 1'b1);
    n_cmp++;
    if (cv_tot !== e_cv || {hex1, hex0, is_break, is_extended} !== {8'h5A, 2'b00}) begin
      n_fail++; $display("FAIL rst_mid_recover: cv=%0d got %h/%b%b required cv=%0d 5A/00",
                         cv_tot, {hex1, hex0}, is_break, is_extended, e_cv);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int         p, kind;
    for (int it = 0; it < 12; it++) begin
      p    = $urandom_range(0, 3);
      kind = $urandom_range(0, 7);
      b    = 8'($urandom_range(0, 255));
      if (b == 8'hE0 || b == 8'hF0) b = 8'h12;
      if (p[0]) frame(8'hE0, 1'b1, 1'b1);
      if (p[1]) frame(8'hF0, 1'b1, 1'b1);
      frame(b, kind != 7, kind != 6);
      n_cmp++;
      if (cv_tot !== e_cv || fe_tot !== e_fe) begin
        n_fail++; $display("FAIL rand_pulses[%0d]: cv=%0d fe=%0d required cv=%0d fe=%0d",
                           it, cv_tot, fe_tot, e_cv, e_fe);
      end
      n_cmp++;
      if ({hex1, hex0, is_break, is_extended} !== {e_hex, e_brk, e_ext}) begin
        n_fail++; $display("FAIL rand_code[%0d]: got %h/%b%b required %h/%b%b",
                           it, {hex1, hex0}, is_break, is_extended, e_hex, e_brk, e_ext);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_parity();
    test_stop_err();
    test_timeout();
    test_glitch();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
